jk_bank_sched: RTL
==================

# jk_bank_sched

Command scheduler and arbiter for a WIDTH-bit register bank built from `jkff` cells (one J/K/q triple per bit, common `clock`). It takes commands from two requesters, arbitrates round-robin, and drives the bank's J/K vectors to clear, set, toggle, load or count. It reads the bank's q outputs as feedback. Only one command owns the bank at a time; when no command is executing, J/K are 00, so every bit holds its value.

## Interface
- WIDTH, 4, number of JK cells in the bank; also the width of `data*` and of the count argument.
- `clock`  in  1  rising-edge clock, shared with the JK bank.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  command request. Held high until the matching `gnt` is seen.
- `op0`, `op1`  in  3  command opcode. Held stable while `req` is high.
- `data0`, `data1`  in  WIDTH  command argument. Held stable while `req` is high.
- `q`  in  WIDTH  bank state feedback.
- `j`, `k`  out  WIDTH  bank J/K drive.
- `gnt0`, `gnt1`  out  1  one-cycle registered acknowledge.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE → EXEC when `req0|req1` at a clock edge. At that same edge the winner's op/data is latched into op_r/arg_r, rem is loaded with data, the winner's `gnt` is set, and the priority pointer is updated.
  - EXEC → DONE when the command completes; otherwise stay in EXEC (COUNT only).
  - DONE → IDLE unconditionally.
- Arbitration:
  - Single requester wins.
  - If both request, the winner is the requester not granted last. The pointer resets to favour `req0`.
- Opcodes and J/K drive in EXEC (bit i):
  - 000 NOP: j=0, k=0.
  - 001 CLEAR: j=0, k=1 (all bits).
  - 010 SET: j=1, k=0 (all bits).
  - 011 TOGGLE: j=1, k=1 (all bits).
  - 100 LOAD: j=arg_r, k=~arg_r.
  - 101 COUNT: increment by 1 per EXEC cycle. j[i]=k[i]=&q[i-1:0]; bit 0 always toggles. The value wraps from all-ones to 0 with no flag.
  - 110 MASKTOG: j=k=arg_r.
  - 111: reserved, executes as NOP.
- Completion for every op except COUNT: a single EXEC cycle, then DONE.
- COUNT completion:
  - If rem==0 on entering EXEC: drive J/K = 00 and go to DONE.
  - Otherwise, each EXEC cycle drives the increment and does rem ← rem−1. Go to DONE when rem==1.
  - Total EXEC cycles = max(data, 1).
- In IDLE and DONE, `j` and `k` are all-zero. `j`/`k` are combinational from state, op_r, arg_r and `q`.
- `done` is high exactly during the DONE cycle.
- `busy` = (state ≠ IDLE).
- Requests arriving during EXEC or DONE are not sampled; they wait for IDLE.

## Timing
- Reset (asynchronous, immediate on the `reset_n` falling edge):
  - state = IDLE, rem = 0, pointer favours 0, op_r = 000, arg_r = 0.
  - `gnt0` = `gnt1` = `busy` = `done` = 0.
  - `j` = `k` = 0.
- Reset mid-operation: the command is aborted with no `done`. Bank bits keep whatever was clocked before reset; the bank has no reset.
- Latency, with a request sampled in IDLE at the edge ending cycle t:
  - Cycle t+1: `gnt` high and first EXEC drive; the bank updates at the end of t+1.
  - Non-COUNT ops: `done` in cycle t+2, IDLE again in t+3. The earliest next grant is at the edge ending t+3.
  - COUNT with n>0: EXEC spans t+1..t+n, `done` in t+n+1.
- Requesters may drop `req` in the cycle after `gnt`. Because of the DONE cycle, a requester that still holds `req` in IDLE is treated as issuing a new request.
- `gnt` is asserted only in the first EXEC cycle of a command.

## Test plan
All scenarios use WIDTH=4 and a bank of 4 `jkff` instances.
- Reset, then SET, then CLEAR: q=1111 then q=0000. Each command gives `gnt0` at t+1 and `done` at t+2; J/K are 00 outside EXEC.
- LOAD data=1010, then MASKTOG data=0110: q=1010, then q=1100.
- COUNT data=5 from q=1101: q steps 1110, 1111, 0000 (wrap), 0001, 0010. There are exactly 5 EXEC cycles, and `done` is in t+6. COUNT data=0 gives one EXEC cycle with J/K=00, q unchanged, and `done` at t+2.
- `req0` and `req1` asserted together and held: grants alternate 0,1,0,1, each 3 cycles apart. A lone `req1` after a `gnt1` is still granted.
- Assert `reset_n`=0 during cycle 3 of a COUNT data=8: all outputs go to 0 immediately, no `done` pulse is seen, and `busy` is 0 after reset is released.
- Opcode 111 with data=1111 from q=0101: q stays 0101 and `done` still pulses.

Source files
------------

// File: rtl/jk_bank_sched.sv
// Round-robin command scheduler for a JK flip-flop register bank: arbitrates two
// requesters and drives J/K to clear, set, toggle, load, mask-toggle or count.
module jk_bank_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_CLEAR   = 3'b001,
    OP_SET     = 3'b010,
    OP_TOGGLE  = 3'b011,
    OP_LOAD    = 3'b100,
    OP_COUNT   = 3'b101,
    OP_MASKTOG = 3'b110,
    OP_RSVD    = 3'b111
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ptr_q, ptr_d;   // 1 = req1 is favoured on a tie
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             win1;
  logic [WIDTH-1:0] carry;

  // Ripple carry for a synchronous JK counter: bit i toggles when all lower bits are 1.
  always_comb begin
    carry[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = carry[i-1] & q[i-1];
    end
  end

  assign win1 = req1 & (~req0 | ptr_q);

  // NOTE: every output of this block gets a default first, so no path can leave a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    j       = '0;
    k       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          state_d = S_EXEC;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          op_d    = op_t'(win1 ? op1 : op0);
          arg_d   = win1 ? data1 : data0;
          rem_d   = win1 ? data1 : data0;
          ptr_d   = ~win1;
        end
      end

      S_EXEC: begin
        state_d = S_DONE;
        unique case (op_q)
          OP_CLEAR:   k = '1;
          OP_SET:     j = '1;
          OP_TOGGLE: begin
            j = '1;
            k = '1;
          end
          OP_LOAD: begin
            j = arg_q;
            k = ~arg_q;
          end
          OP_MASKTOG: begin
            j = arg_q;
            k = arg_q;
          end
          OP_COUNT: begin
            // A zero count still spends one idle EXEC cycle.
            if (rem_q != '0) begin
              j     = carry;
              k     = carry;
              rem_d = rem_q - 1'b1;
              if (rem_q != WIDTH'(1)) state_d = S_EXEC;
            end
          end
          default: ;
        endcase
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      arg_q   <= '0;
      rem_q   <= '0;
      ptr_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule
